branch_logic: RTL and testbench
===============================

Name: branch_logic

Overview:
- Branch-resolution block in the RISC-V EX stage.
- Combines the branch enable and the B-type funct3 with ALU comparison flags (zero, signed less-than, unsigned less-than) to decide whether a conditional branch is taken.
- Provides a combinational decision for same-cycle PC redirect, plus a registered copy for the pipeline/hazard unit.
- Optionally keeps branch statistics counters.

Parameters:
- CNT_W, 32, width of the statistics counters (used only with BRANCH_LOGIC_STATS_EN).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- branch  input  1  current instruction is a conditional branch (B-type).
- funct3  input  3  branch condition code.
- zero_flag  input  1  rs1 == rs2 (ALU subtract result is zero).
- less_than  input  1  rs1 < rs2, signed.
- less_than_u  input  1  rs1 < rs2, unsigned.
- taken  output  1  combinational branch-taken decision.
- invalid_funct3  output  1  combinational; branch=1 with an unsupported funct3.
- taken_q  output  1  taken registered on clk.
- stats_clr  input  1  synchronous clear of statistics counters (BRANCH_LOGIC_STATS_EN only).
- branch_cnt  output  CNT_W  branches seen (BRANCH_LOGIC_STATS_EN only).
- taken_cnt  output  CNT_W  branches taken (BRANCH_LOGIC_STATS_EN only).

Behaviour:
- Decision is purely combinational with zero latency. taken is 0 whenever branch=0, regardless of flags or funct3.
- With branch=1, taken is decoded from funct3 as follows:
  - 000 BEQ: taken = zero_flag.
  - 001 BNE: taken = ~zero_flag.
  - 100 BLT: taken = less_than.
  - 101 BGE: taken = ~less_than.
  - 110 BLTU: taken = less_than_u.
  - 111 BGEU: taken = ~less_than_u.
  - 010, 011: taken = 0 and invalid_funct3 = 1.
- Each condition reads only its own flag. Other flags are ignored; for example, BEQ with all flags at 1 gives taken=1.
- invalid_funct3 = branch & (funct3 == 010 or 011). It is 0 when branch=0.
- No X propagation: every funct3 value drives a defined output. Use default-case assignments of 0.
- taken_q follows taken one cycle later (registered on the rising edge of clk).
- Reset: asserting rst clears taken_q to 0 and clears the counters to 0 immediately (asynchronous). The combinational outputs stay live during reset.
- Reset released mid-operation: taken_q captures taken on the first rising edge after deassertion.

Optional Feature:
- Macro: BRANCH_LOGIC_STATS_EN.
- Defined:
  - branch_cnt increments on each clk edge where branch=1.
  - taken_cnt increments on each clk edge where taken=1.
  - Both counters wrap modulo 2^CNT_W.
  - stats_clr=1 synchronously zeroes both counters and has priority over increment.
  - rst clears both counters asynchronously.
- Undefined: stats_clr, branch_cnt and taken_cnt ports are absent and no counter flops are generated. Decision behaviour is unchanged.

Decomposition:
- Shared package branch_pkg holds the funct3 localparams: F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101, F3_BLTU=110, F3_BGEU=111. The decoder and the control unit reuse them.
- One natural sub-module, branch_cond_decode: purely combinational decode of funct3 and the flags into a raw condition and an invalid flag.
- The top level adds branch gating, the taken_q register and the optional counters.

Test Plan:
- branch=0, funct3=000, zero_flag=1 -> taken=0, invalid_funct3=0. After the clk edge, taken_q=0.
- Conditions with branch=1, each in both polarities:
  - BEQ: zero_flag=1 -> taken=1; zero_flag=0 -> taken=0.
  - BNE: zero_flag=0 -> taken=1; zero_flag=1 -> taken=0.
  - BLT: less_than=1 -> 1; less_than=0 -> 0.
  - BGE: less_than=0 -> 1; less_than=1 -> 0.
  - BLTU: less_than_u=1 -> 1; less_than_u=0 -> 0.
  - BGEU: less_than_u=0 -> 1; less_than_u=1 -> 0.
- Invalid code and flag isolation:
  - funct3=010 with all flags=1 -> taken=0, invalid_funct3=1.
  - With all flags=1: BEQ, BLT and BLTU each give taken=1.
- Signed vs unsigned, -5 vs 10 (less_than=1, less_than_u=0, zero_flag=0) -> BLT taken=1, BLTU taken=0.
- Register and reset:
  - Drive BEQ with zero_flag=1; clk edge -> taken_q=1.
  - Assert rst between edges -> taken_q=0 immediately, while taken stays 1.
- With BRANCH_LOGIC_STATS_EN, after reset:
  - 5 branch cycles (3 taken) plus 2 non-branch cycles -> branch_cnt=5, taken_cnt=3.
  - stats_clr=1 for one cycle -> both 0.
  - With CNT_W=4, 17 branch cycles -> branch_cnt=1 (wrap).

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch definitions: B-type funct3 condition codes.
// Used by the branch condition decoder and the control unit.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic zero;
    logic lt;
    logic ltu;
  } br_flags_t;

  function automatic logic f3_is_invalid(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/branch_cond_decode.sv
// Combinational funct3 + ALU flag decode into a raw branch condition.
// No branch gating here; the top level qualifies both outputs.
module branch_cond_decode
  import branch_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  br_flags_t  flags_i,
  output logic       cond_o,
  output logic       invalid_o
);

  always_comb begin
    cond_o    = 1'b0;
    invalid_o = f3_is_invalid(funct3_i);
    case (funct3_i)
      F3_BEQ:  cond_o = flags_i.zero;
      F3_BNE:  cond_o = ~flags_i.zero;
      F3_BLT:  cond_o = flags_i.lt;
      F3_BGE:  cond_o = ~flags_i.lt;
      F3_BLTU: cond_o = flags_i.ltu;
      F3_BGEU: cond_o = ~flags_i.ltu;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_logic.sv
// EX-stage branch resolution: same-cycle taken plus registered taken_q.
// Optional statistics counters enabled by BRANCH_LOGIC_STATS_EN.
module branch_logic
  import branch_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch,
  input  logic [2:0]       funct3,
  input  logic             zero_flag,
  input  logic             less_than,
  input  logic             less_than_u,
  output logic             taken,
  output logic             invalid_funct3,
`ifdef BRANCH_LOGIC_STATS_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
`endif
  output logic             taken_q
);

  br_flags_t flags;
  logic      cond;
  logic      invalid;
  logic      taken_q_q;

  assign flags = '{zero: zero_flag, lt: less_than, ltu: less_than_u};

  branch_cond_decode u_dec (
    .funct3_i  (funct3),
    .flags_i   (flags),
    .cond_o    (cond),
    .invalid_o (invalid)
  );

  assign taken          = branch & cond;
  assign invalid_funct3 = branch & invalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) taken_q_q <= 1'b0;
    else     taken_q_q <= taken;
  end

  assign taken_q = taken_q_q;

`ifdef BRANCH_LOGIC_STATS_EN
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  // Clear wins over increment; counters wrap naturally.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (stats_clr) begin
      branch_cnt_d = '0;
      taken_cnt_d  = '0;
    end else begin
      if (branch) branch_cnt_d = branch_cnt_q + 1'b1;
      if (taken)  taken_cnt_d  = taken_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_logic.sv
// Directed table-driven bench for branch_logic.
// Counter checks are compiled in with BRANCH_LOGIC_STATS_EN.
module tb_branch_logic;

  localparam int CW = 4;

  logic       clk;
  logic       rst;
  logic       branch;
  logic [2:0] funct3;
  logic       zero_flag;
  logic       less_than;
  logic       less_than_u;
  logic       taken;
  logic       invalid_funct3;
  logic       taken_q;
`ifdef BRANCH_LOGIC_STATS_EN
  logic          stats_clr;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] taken_cnt;
`endif

  int n_run;
  int n_fail;

  branch_logic #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .branch         (branch),
    .funct3         (funct3),
    .zero_flag      (zero_flag),
    .less_than      (less_than),
    .less_than_u    (less_than_u),
    .taken          (taken),
    .invalid_funct3 (invalid_funct3),
`ifdef BRANCH_LOGIC_STATS_EN
    .stats_clr      (stats_clr),
    .branch_cnt     (branch_cnt),
    .taken_cnt      (taken_cnt),
`endif
    .taken_q        (taken_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       br;
    logic [2:0] f3;
    logic       z;
    logic       lt;
    logic       ltu;
    logic       exp_tk;
    logic       exp_inv;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic br, input logic [2:0] f3,
                       input logic z, input logic lt, input logic ltu);
    branch      = br;
    funct3      = f3;
    zero_flag   = z;
    less_than   = lt;
    less_than_u = ltu;
  endtask

  task automatic addv(input logic br, input logic [2:0] f3,
                      input logic z, input logic lt, input logic ltu,
                      input logic tk, input logic inv, input string nm);
    vec_t v;
    v.br = br; v.f3 = f3; v.z = z; v.lt = lt; v.ltu = ltu;
    v.exp_tk = tk; v.exp_inv = inv; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
`ifdef BRANCH_LOGIC_STATS_EN
    stats_clr = 1'b0;
`endif

    addv(0, 3'b000, 1, 0, 0, 0, 0, "nobr_beq");
    addv(0, 3'b010, 1, 1, 1, 0, 0, "nobr_inv");
    addv(1, 3'b000, 1, 0, 0, 1, 0, "beq_t");
    addv(1, 3'b000, 0, 0, 0, 0, 0, "beq_nt");
    addv(1, 3'b001, 0, 0, 0, 1, 0, "bne_t");
    addv(1, 3'b001, 1, 0, 0, 0, 0, "bne_nt");
    addv(1, 3'b100, 0, 1, 0, 1, 0, "blt_t");
    addv(1, 3'b100, 0, 0, 0, 0, 0, "blt_nt");
    addv(1, 3'b101, 0, 0, 0, 1, 0, "bge_t");
    addv(1, 3'b101, 0, 1, 0, 0, 0, "bge_nt");
    addv(1, 3'b110, 0, 0, 1, 1, 0, "bltu_t");
    addv(1, 3'b110, 0, 0, 0, 0, 0, "bltu_nt");
    addv(1, 3'b111, 0, 0, 0, 1, 0, "bgeu_t");
    addv(1, 3'b111, 0, 0, 1, 0, 0, "bgeu_nt");
    addv(1, 3'b010, 1, 1, 1, 0, 1, "inv010");
    addv(1, 3'b011, 1, 1, 1, 0, 1, "inv011");
    addv(1, 3'b000, 1, 1, 1, 1, 0, "beq_all1");
    addv(1, 3'b100, 1, 1, 1, 1, 0, "blt_all1");
    addv(1, 3'b110, 1, 1, 1, 1, 0, "bltu_all1");
    addv(1, 3'b100, 0, 1, 0, 1, 0, "blt_m5_10");
    addv(1, 3'b110, 0, 1, 0, 0, 0, "bltu_m5_10");

    // Reset state; combinational path is live under reset.
    #2;
    chk("rst_taken_q", taken_q, 0);
    drive(1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rst_comb_live", taken, 1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].br, vecs[i].f3, vecs[i].z, vecs[i].lt, vecs[i].ltu);
      #1;
      chk({vecs[i].name, "_taken"}, taken, vecs[i].exp_tk);
      chk({vecs[i].name, "_inv"}, invalid_funct3, vecs[i].exp_inv);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_taken_q"}, taken_q, vecs[i].exp_tk);
    end

    // Async reset between edges while taken stays high.
    @(negedge clk);
    drive(1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("seq_taken_q_set", taken_q, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("seq_async_clr", taken_q, 0);
    chk("seq_taken_live", taken, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("seq_hold_until_edge", taken_q, 0);
    @(posedge clk);
    #1;
    chk("seq_first_edge", taken_q, 1);

`ifdef BRANCH_LOGIC_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("st_rst_bcnt", branch_cnt, 0);
    chk("st_rst_tcnt", taken_cnt, 0);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: drive(1, 3'b000, 1, 0, 0);
        1: drive(1, 3'b001, 1, 0, 0);
        2: drive(0, 3'b000, 1, 1, 1);
        3: drive(1, 3'b100, 0, 1, 0);
        4: drive(1, 3'b110, 0, 0, 0);
        5: drive(0, 3'b001, 0, 0, 0);
        default: drive(1, 3'b111, 0, 0, 0);
      endcase
      @(negedge clk);
    end
    drive(0, 3'b000, 0, 0, 0);
    chk("st_bcnt5", branch_cnt, 5);
    chk("st_tcnt3", taken_cnt, 3);
    stats_clr = 1'b1;
    drive(1, 3'b000, 1, 0, 0);
    @(negedge clk);
    stats_clr = 1'b0;
    drive(0, 3'b000, 0, 0, 0);
    chk("st_clr_bcnt", branch_cnt, 0);
    chk("st_clr_tcnt", taken_cnt, 0);
    drive(1, 3'b000, 0, 0, 0);
    for (int k = 0; k < 17; k++) @(negedge clk);
    drive(0, 3'b000, 0, 0, 0);
    chk("st_wrap_bcnt", branch_cnt, 1);
    chk("st_wrap_tcnt", taken_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
